// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order core: ALU opcode encoding, CDB packet
// layout and the default ROB tag width.
package ooo_pkg;

    localparam int ROB_ADDR_WIDTH = 4;

    // 4-bit ALU opcodes issued by the ALU reservation station.
    // Codes 11..15 are unused and produce a zero result.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    // One result broadcast on the Common Data Bus.
    typedef struct packed {
        logic [ROB_ADDR_WIDTH-1:0] tag;
        logic [31:0]               data;
    } cdb_pkt_t;

endpackage

// File: rtl/alu_result_fifo.sv
// Small in-order result buffer between the execute register and the CDB.
// Storage, pointers and count are all cleared by reset or flush so that the
// head reads as zero afterwards. The head is a direct read of a storage
// register, so there is no combinational path from push data to the head.
module alu_result_fifo
    import ooo_pkg::*;
#(
    parameter int  DEPTH     = 2,
    parameter type payload_t = cdb_pkt_t
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     flush,
    input  logic     push,
    input  payload_t push_data,
    input  logic     pop,
    output logic     full,
    output logic     empty,
    output payload_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    payload_t         mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    logic push_ok_s;
    logic pop_ok_s;

    // Status flags and qualified push/pop; a push into a full buffer is only
    // taken when the head leaves in the same cycle.
    always_comb begin
        full      = (count_r == FULL_COUNT);
        empty     = (count_r == '0);
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
        head      = mem_r[rd_ptr_r];
    end

    // Storage, pointer and occupancy update; reset and flush discard everything.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Single-cycle RV32I integer ALU execution stage. The result is computed from
// the issue inputs, captured in the execute register E, moved into a result
// FIFO and broadcast on the CDB under a request/grant handshake.
module alu_exec_unit
    import ooo_pkg::*;
#(
    parameter int ROB_ADDR_WIDTH = ooo_pkg::ROB_ADDR_WIDTH,
    parameter int RESULT_DEPTH   = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic [3:0]                issue_alu_op,
    input  logic [31:0]               issue_src1_value,
    input  logic [31:0]               issue_src2_value,
    input  logic [ROB_ADDR_WIDTH-1:0] issue_dest_tag,
    output logic                      issue_ready,
    input  logic                      flush,
    output logic                      cdb_req,
    output logic [ROB_ADDR_WIDTH-1:0] cdb_tag,
    output logic [31:0]               cdb_data,
    input  logic                      cdb_grant
);

    // Local packet type so the tag width follows this instance's parameter.
    typedef struct packed {
        logic [ROB_ADDR_WIDTH-1:0] tag;
        logic [31:0]               data;
    } pkt_t;

    // RV32I integer ALU; shifts use only the low five bits of operand B.
    function automatic logic [31:0] alu_compute(input alu_op_e op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        logic [4:0]  shamt;
        logic [31:0] res;
        shamt = b[4:0];
        res   = 32'd0;
        case (op)
            ALU_ADD:   res = a + b;
            ALU_SUB:   res = a - b;
            ALU_SLL:   res = a << shamt;
            ALU_SLT:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU:  res = (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:   res = a ^ b;
            ALU_SRL:   res = a >> shamt;
            ALU_SRA:   res = 32'($signed(a) >>> shamt);
            ALU_OR:    res = a | b;
            ALU_AND:   res = a & b;
            ALU_PASSB: res = b;
            default:   res = 32'd0;
        endcase
        return res;
    endfunction

    logic                      e_valid_r;
    logic [ROB_ADDR_WIDTH-1:0] e_tag_r;
    logic [31:0]               e_data_r;

    logic [31:0] alu_result_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        pop_s;
    logic        drain_s;
    logic        accept_s;
    pkt_t        push_pkt_s;
    pkt_t        head_pkt_s;

    // Issue-side datapath and handshake. issue_ready depends on cdb_grant
    // because a pop frees the slot E needs to drain into. It is also held
    // high during reset and flush so the reservation station can drain.
    always_comb begin
        alu_result_s    = alu_compute(alu_op_e'(issue_alu_op),
                                      issue_src1_value, issue_src2_value);
        pop_s           = !fifo_empty_s && cdb_grant;
        drain_s         = e_valid_r && (!fifo_full_s || pop_s);
        issue_ready     = reset || flush || !e_valid_r || drain_s;
        accept_s        = issue_valid && issue_ready;
        push_pkt_s.tag  = e_tag_r;
        push_pkt_s.data = e_data_r;
    end

    // Execute register E: squashed by reset or flush, loaded on accept,
    // emptied once its result has moved into the FIFO.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            e_valid_r <= 1'b0;
            e_tag_r   <= '0;
            e_data_r  <= 32'd0;
        end else if (accept_s) begin
            e_valid_r <= 1'b1;
            e_tag_r   <= issue_dest_tag;
            e_data_r  <= alu_result_s;
        end else if (drain_s) begin
            e_valid_r <= 1'b0;
        end else begin
            e_valid_r <= e_valid_r;
        end
    end

    alu_result_fifo #(
        .DEPTH     (RESULT_DEPTH),
        .payload_t (pkt_t)
    ) u_result_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .push      (drain_s),
        .push_data (push_pkt_s),
        .pop       (pop_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .head      (head_pkt_s)
    );

    // CDB side is driven only from FIFO state, never from the issue inputs.
    always_comb begin
        cdb_req  = !fifo_empty_s;
        cdb_tag  = head_pkt_s.tag;
        cdb_data = head_pkt_s.data;
    end

endmodule
